limit_debounce: RTL and testbench

Input-conditioning stage for the motion limit/interlock block. It synchronises the eight raw field inputs (interlock A/B and limit -, 0, + for axes A and B) into the fabric clock and debounces them per channel. It emits clean levels, single-cycle edge pulses and software-clearable sticky flags. The debounced levels feed the limit/interrupt stage directly, replacing the raw pins, so switch bounce cannot toggle `o_intr_A/B`.

---
 rtl/limit_debounce.sv | 90 +++++++++
 tb/tb_limit_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/limit_debounce.sv
// limit_debounce: input conditioning for the motion limit/interlock block.
// Eight raw field pins are synchronised into the fabric clock, polarity
// corrected and debounced per channel. Outputs are clean levels, one-cycle
// edge pulses, software-clearable sticky flags and a registered OR.
//
// Channel order: [0] interlock_A [1] limit_m_A [2] limit_0_A [3] limit_p_A
//                [4] interlock_B [5] limit_m_B [6] limit_0_B [7] limit_p_B
//
// Ports:
//   i_clk      fabric clock, rising edge
//   i_rst      synchronous active-high reset
//   i_raw      asynchronous switch inputs
//   i_clr      per-channel sticky-flag clear (one-cycle pulse)
//   o_level    debounced, polarity-corrected level (1 = active)
//   o_rise     one-cycle pulse on o_level 0->1
//   o_fall     one-cycle pulse on o_level 1->0
//   o_latched  sticky flag, set on rise, cleared by i_clr (set wins)
//   o_any      OR of o_level, one cycle later
module limit_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 100000,
  parameter logic [7:0]  INVERT_MASK  = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_raw,
  input  logic [7:0] i_clr,
  output logic [7:0] o_level,
  output logic [7:0] o_rise,
  output logic [7:0] o_fall,
  output logic [7:0] o_latched,
  output logic       o_any
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic [7:0]         s1;
  logic [7:0]         s2;
  logic [7:0]         sync;
  logic [7:0]         stable;
  logic [7:0]         mismatch;
  logic [7:0]         expire;
  logic [7:0]         toggle;
  logic [7:0][CW-1:0] cnt;

  always_comb begin
    sync     = s2 ^ INVERT_MASK;
    mismatch = sync ^ stable;
    expire   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      expire[i] = (cnt[i] == LAST);
    end
    // A channel toggles on the cycle that completes DEBOUNCE_CNT
    // consecutive mismatching samples.
    toggle = mismatch & expire;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchronisers load the inactive pin level so a pin already active
      // at release still has to travel the full pipeline and count.
      s1        <= INVERT_MASK;
      s2        <= INVERT_MASK;
      stable    <= '0;
      cnt       <= '0;
      o_rise    <= '0;
      o_fall    <= '0;
      o_latched <= '0;
      o_any     <= 1'b0;
    end else begin
      s1        <= i_raw;
      s2        <= s1;
      stable    <= stable ^ toggle;
      o_rise    <= toggle & ~stable;
      o_fall    <= toggle & stable;
      o_latched <= (o_latched & ~i_clr) | (toggle & ~stable);
      o_any     <= |stable;
      for (int unsigned i = 0; i < 8; i++) begin
        if (!mismatch[i] || expire[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign o_level = stable;

endmodule

// File: tb/tb_limit_debounce.sv
// Testbench for limit_debounce: directed vector table, hand-written corner
// sequences and randomized stimulus compared against a history-based model.
module tb_limit_debounce;

  localparam int unsigned N    = 4;
  localparam logic [7:0]  MASK = 8'h80;
  localparam logic [7:0]  IDLE = 8'h80;   // all pins at their inactive level

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw;
  logic [7:0] clr;
  logic [7:0] o_level, o_rise, o_fall, o_latched;
  logic       o_any;

  always #5 clk = ~clk;

  limit_debounce #(.DEBOUNCE_CNT(N), .INVERT_MASK(MASK)) dut (
    .i_clk(clk), .i_rst(rst), .i_raw(raw), .i_clr(clr),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_latched(o_latched), .o_any(o_any)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel accepts a new value once the last N
  // synchronised samples all disagree with its current accepted value.
  logic [7:0] m_pipe[$];     // raw values in flight through the synchroniser
  logic [7:0] m_hist[$];     // recent synchronised samples, newest last
  logic [7:0] m_stable, m_rise, m_fall, m_lat;
  logic       m_any;

  task automatic model_step();
    logic [7:0] sy;
    logic [7:0] tog;
    bit all;
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back(MASK);
      m_pipe.push_back(MASK);
      m_hist.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_lat = '0; m_any = 1'b0;
    end else begin
      sy = m_pipe[0] ^ MASK;
      void'(m_pipe.pop_front());
      m_pipe.push_back(raw);
      m_hist.push_back(sy);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      tog = '0;
      if (m_hist.size() == N) begin
        for (int ch = 0; ch < 8; ch++) begin
          all = 1;
          foreach (m_hist[k]) if (m_hist[k][ch] == m_stable[ch]) all = 0;
          tog[ch] = all;
        end
      end
      m_any    = |m_stable;
      m_rise   = tog & ~m_stable;
      m_fall   = tog & m_stable;
      m_lat    = (m_lat & ~clr) | m_rise;
      m_stable = m_stable ^ tog;
    end
  endtask

  task automatic tick(input logic [7:0] r, input logic [7:0] c, input logic rs);
    raw = r; clr = c; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_level",   o_level,   m_stable);
    chk("model_rise",    o_rise,    m_rise);
    chk("model_fall",    o_fall,    m_fall);
    chk("model_latched", o_latched, m_lat);
    chk("model_any",     {7'b0, o_any}, {7'b0, m_any});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(IDLE, (i == n - 1) ? 8'hFF : 8'h00, 1'b0);
  endtask

  typedef struct {
    logic [7:0] raw, clr, lvl, rise, fall, lat;
    logic       any;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] seen;
  logic [7:0] cur;
  int rem[8];

  initial begin
    // Clean step on channel 1, then release with a clear on the way down.
    for (int k = 0; k < 5; k++) tbl[k] = '{8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{8'h82, 8'h00, 8'h02, 8'h02, 8'h00, 8'h02, 1'b0};
    tbl[6]  = '{8'h82, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[7]  = '{IDLE,  8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1};
    for (int k = 8; k < 12; k++) tbl[k] = '{IDLE, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{IDLE,  8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 1'b1};
    tbl[13] = '{IDLE,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset with channel 7 pin held high (inactive under inversion).
    for (int i = 0; i < 3; i++) tick(IDLE, 8'h00, 1'b1);
    chk("reset_level",   o_level,   8'h00);
    chk("reset_rise",    o_rise,    8'h00);
    chk("reset_fall",    o_fall,    8'h00);
    chk("reset_latched", o_latched, 8'h00);
    chk("reset_any",     {7'b0, o_any}, 8'h00);
    idle(8);
    chk("idle_level7", {7'b0, o_level[7]}, 8'h00);

    for (int k = 0; k < 14; k++) begin
      tick(tbl[k].raw, tbl[k].clr, 1'b0);
      chk("tbl_level",   o_level,   tbl[k].lvl);
      chk("tbl_rise",    o_rise,    tbl[k].rise);
      chk("tbl_fall",    o_fall,    tbl[k].fall);
      chk("tbl_latched", o_latched, tbl[k].lat);
      chk("tbl_any",     {7'b0, o_any}, {7'b0, tbl[k].any});
    end
    idle(4);

    // Glitch on channel 3: 3-cycle pulse rejected.
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      tick((i < 3) ? 8'h88 : IDLE, 8'h00, 1'b0);
      seen = seen | o_rise | o_level | o_latched;
    end
    chk("glitch_rejected", {7'b0, seen[3]}, 8'h00);
    // 4-cycle pulse accepted.
    for (int i = 0; i < 12; i++) begin
      tick((i < 4) ? 8'h88 : IDLE, 8'h00, 1'b0);
      if (i == 4) chk("pulse4_not_early", {7'b0, o_rise[3]}, 8'h00);
      if (i == 5) chk("pulse4_rise",      {7'b0, o_rise[3]}, 8'h01);
      if (i == 9) chk("pulse4_fall",      {7'b0, o_fall[3]}, 8'h01);
    end
    idle(4);

    // Bounce on channel 0: high 3, low 1, then high held.
    for (int i = 0; i < 12; i++) begin
      tick((i == 3) ? IDLE : 8'h81, 8'h00, 1'b0);
      if (i == 8) chk("bounce_not_early", {7'b0, o_level[0]}, 8'h00);
      if (i == 9) chk("bounce_rise",      {7'b0, o_rise[0]},  8'h01);
    end
    idle(10);

    // Sticky clear on channel 5, then clear coinciding with a new rise.
    for (int i = 0; i < 23; i++) begin
      if (i < 8)       tick(8'hA0, (i == 7) ? 8'h20 : 8'h00, 1'b0);
      else if (i < 15) tick(IDLE, 8'h00, 1'b0);
      else             tick(8'hA0, (i == 20) ? 8'h20 : 8'h00, 1'b0);
      if (i == 5)  chk("sticky_set",       {7'b0, o_latched[5]}, 8'h01);
      if (i == 7)  chk("sticky_cleared",   {7'b0, o_latched[5]}, 8'h00);
      if (i == 13) chk("sticky_fall",      {7'b0, o_fall[5]},    8'h01);
      if (i == 20) chk("set_wins_rise",    {7'b0, o_rise[5]},    8'h01);
      if (i == 20) chk("set_wins_latched", {7'b0, o_latched[5]}, 8'h01);
      if (i == 21) chk("set_wins_hold",    {7'b0, o_latched[5]}, 8'h01);
    end
    idle(10);

    // Polarity on channel 7 (active-low pin).
    for (int i = 0; i < 16; i++) begin
      tick((i < 8) ? 8'h00 : IDLE, 8'h00, 1'b0);
      if (i == 4)  chk("pol_not_early", {7'b0, o_level[7]}, 8'h00);
      if (i == 5)  chk("pol_rise",      {7'b0, o_rise[7]},  8'h01);
      if (i == 13) chk("pol_fall",      {7'b0, o_fall[7]},  8'h01);
    end
    idle(4);

    // Reset mid-count on channel 2.
    for (int i = 0; i < 12; i++) begin
      tick(8'h84, 8'h00, (i == 3) ? 1'b1 : 1'b0);
      if (i == 3) begin
        chk("midrst_level",   o_level,   8'h00);
        chk("midrst_latched", o_latched, 8'h00);
        chk("midrst_any",     {7'b0, o_any}, 8'h00);
      end
      if (i == 8) chk("midrst_not_early", {7'b0, o_level[2]}, 8'h00);
      if (i == 9) chk("midrst_rise",      {7'b0, o_rise[2]},  8'h01);
    end
    idle(10);

    // Randomized: per-channel hold lengths straddling the debounce window.
    cur = IDLE;
    for (int ch = 0; ch < 8; ch++) rem[ch] = $urandom_range(1, 8);
    for (int t = 0; t < 3000; t++) begin
      for (int ch = 0; ch < 8; ch++) begin
        rem[ch]--;
        if (rem[ch] <= 0) begin
          cur[ch] = ~cur[ch];
          rem[ch] = $urandom_range(1, 8);
        end
      end
      tick(cur, ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
